id_exe_stage_reg: RTL

//  ID->EXE pipeline register, directly downstream of the decoder control unit.
//  - Captures the decoded control bits (WB_EN, MEM_R, MEM_W, B, S, EXE_CMD) plus operands and fields.
//  - Squashes the instruction (bubble) on condition failure, hazard or branch flush.
//  - Holds on a memory stall and counts inserted bubbles for performance monitoring.

---
 rtl/id_exe_stage_reg_pkg.sv | 74 +++++++
 rtl/id_exe_stage_reg_condition_check.sv | 43 ++++
 rtl/id_exe_stage_reg.sv | 130 +++++++++++++
 3 files changed

// File: rtl/id_exe_stage_reg_pkg.sv
// Shared decode definitions for the ID/EXE boundary.
// Contents: ARM condition codes, data-processing opcodes, EXE ALU command
// encodings, instruction mode encodings and status-flag bit positions.
package id_exe_stage_reg_pkg;

  // ARM condition field, EQ..AL plus the never-execute code.
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Instruction class decoded from bits [27:26].
  typedef enum logic [1:0] {
    MODE_ARITH  = 2'b00,
    MODE_MEM    = 2'b01,
    MODE_BRANCH = 2'b10
  } mode_e;

  // Data-processing opcode field.
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // ALU command driven into EXE. Several opcodes share a command
  // (CMP uses SUB, TST uses AND, LDR/STR use ADD for address generation).
  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_CMP = EXE_SUB;
  localparam logic [3:0] EXE_TST = EXE_AND;
  localparam logic [3:0] EXE_LDR = EXE_ADD;
  localparam logic [3:0] EXE_STR = EXE_ADD;

  // Bit positions inside the 4-bit status word {N,Z,C,V}.
  localparam int unsigned STATUS_N = 3;
  localparam int unsigned STATUS_Z = 2;
  localparam int unsigned STATUS_C = 1;
  localparam int unsigned STATUS_V = 0;

endpackage

// File: rtl/id_exe_stage_reg_condition_check.sv
// condition_check: combinational ARM condition evaluation.
// Ports:
//   cond_i      4-bit condition field of the instruction
//   status_i    current flags {N,Z,C,V}
//   cond_pass_o 1 when the instruction should execute
module condition_check
  import id_exe_stage_reg_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] status_i,
  output logic       cond_pass_o
);

  logic n, z, c, v;

  assign n = status_i[STATUS_N];
  assign z = status_i[STATUS_Z];
  assign c = status_i[STATUS_C];
  assign v = status_i[STATUS_V];

  always_comb begin
    cond_pass_o = 1'b0;
    case (cond_e'(cond_i))
      COND_EQ: cond_pass_o = z;
      COND_NE: cond_pass_o = ~z;
      COND_CS: cond_pass_o = c;
      COND_CC: cond_pass_o = ~c;
      COND_MI: cond_pass_o = n;
      COND_PL: cond_pass_o = ~n;
      COND_VS: cond_pass_o = v;
      COND_VC: cond_pass_o = ~v;
      COND_HI: cond_pass_o = c & ~z;
      COND_LS: cond_pass_o = ~c | z;
      COND_GE: cond_pass_o = (n == v);
      COND_LT: cond_pass_o = (n != v);
      COND_GT: cond_pass_o = ~z & (n == v);
      COND_LE: cond_pass_o = z | (n != v);
      COND_AL: cond_pass_o = 1'b1;
      default: cond_pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID->EXE pipeline register.
// Captures decoded control bits, operands and instruction fields one cycle
// after decode. Control bits are squashed on a branch flush, a data hazard
// or a failed condition; everything freezes while hold is high. Squashed
// slots are counted in a saturating bubble counter.
// Ports:
//   clk, rst (sync, active-high), hold, flush, hazard
//   cond, status                          condition evaluation inputs
//   *_in                                  decoded control/operand/field inputs
//   wb_en..src2, status_q                 registered outputs
//   bubble_cnt                            saturating bubble count
module id_exe_stage_reg
  import id_exe_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              hazard,
  input  logic [3:0]        cond,
  input  logic [3:0]        status,
  input  logic              wb_en_in,
  input  logic              mem_r_in,
  input  logic              mem_w_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_op_in,
  input  logic [23:0]       simm24_in,
  input  logic [3:0]        dest_in,
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  output logic              wb_en,
  output logic              mem_r,
  output logic              mem_w,
  output logic              b,
  output logic              s,
  output logic [3:0]        exe_cmd,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic              imm,
  output logic [11:0]       shift_op,
  output logic [23:0]       simm24,
  output logic [3:0]        dest,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic [3:0]        status_q,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic             cond_pass;
  logic             squash;
  logic [CNT_W-1:0] bubble_cnt_d;

  condition_check u_condition_check (
    .cond_i      (cond),
    .status_i    (status),
    .cond_pass_o (cond_pass)
  );

  // Flush and bubble clear the same bits, so one squash term covers both
  // and a simultaneous flush+hazard is counted once.
  always_comb begin
    squash       = flush | hazard | ~cond_pass;
    bubble_cnt_d = bubble_cnt;
    if (squash && (bubble_cnt != '1)) begin
      bubble_cnt_d = bubble_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en      <= 1'b0;
      mem_r      <= 1'b0;
      mem_w      <= 1'b0;
      b          <= 1'b0;
      s          <= 1'b0;
      exe_cmd    <= EXE_NOP;
      pc         <= '0;
      val_rn     <= '0;
      val_rm     <= '0;
      imm        <= 1'b0;
      shift_op   <= '0;
      simm24     <= '0;
      dest       <= '0;
      src1       <= '0;
      src2       <= '0;
      status_q   <= '0;
      bubble_cnt <= '0;
    end else if (!hold) begin
      // Data fields and source indices load even in squashed slots so
      // forwarding logic still sees the register indices.
      pc         <= pc_in;
      val_rn     <= val_rn_in;
      val_rm     <= val_rm_in;
      imm        <= imm_in;
      shift_op   <= shift_op_in;
      simm24     <= simm24_in;
      dest       <= dest_in;
      src1       <= src1_in;
      src2       <= src2_in;
      status_q   <= status;
      bubble_cnt <= bubble_cnt_d;
      if (squash) begin
        wb_en   <= 1'b0;
        mem_r   <= 1'b0;
        mem_w   <= 1'b0;
        b       <= 1'b0;
        s       <= 1'b0;
        exe_cmd <= EXE_NOP;
      end else begin
        wb_en   <= wb_en_in;
        mem_r   <= mem_r_in;
        mem_w   <= mem_w_in;
        b       <= b_in;
        s       <= s_in;
        exe_cmd <= exe_cmd_in;
      end
    end
  end

endmodule
